// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute-stage ALU.
//   Logic/arithmetic ops complete in one cycle. Shifts run one bit per cycle
//   through an iterative shifter unless ALU_FAST_SHIFT_EN is defined, in which
//   case a combinational barrel shifter gives every op a latency of 1.
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   in_valid/in_ready request handshake (aluctrl, src_a, src_b sampled on accept)
//   aluctrl           AND=0 OR=1 ADD=2 SUB=3 XOR=4 SLT=5 SLL=6 SRL=7 SRA=8, else result 0
//   src_a, src_b      operands; src_b[SW-1:0] is the shift amount
//   out_valid/out_ready result handshake
//   result, zero      registered result and (result == 0) flag
// Build option: ALU_FAST_SHIFT_EN (barrel shifter, no SHIFT state/counter).
module alu_exec_unit #(
  parameter int XLEN = 32,
  localparam int SW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      aluctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2,
                         OP_SUB = 4'd3, OP_XOR = 4'd4, OP_SLT = 4'd5,
                         OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic {S_IDLE, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t          state, state_nxt;
  logic            accept, wr_res;
  logic [XLEN-1:0] alu_res, res_nxt;
  logic [SW-1:0]   shamt;

  assign shamt     = src_b[SW-1:0];
  assign out_valid = (state == S_DONE);
  // In the fast build this is exactly !out_valid || out_ready.
  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  // Single-cycle result. In the iterative build shifts only land here with
  // shamt == 0, so the source passes straight through.
  always_comb begin
    alu_res = '0;
    case (aluctrl)
      OP_AND: alu_res = src_a & src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_ADD: alu_res = src_a + src_b;
      OP_SUB: alu_res = src_a - src_b;
      OP_XOR: alu_res = src_a ^ src_b;
      OP_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: alu_res = src_a << shamt;
      OP_SRL: alu_res = src_a >> shamt;
      OP_SRA: alu_res = $unsigned($signed(src_a) >>> shamt);
`else
      OP_SLL, OP_SRL, OP_SRA: alu_res = src_a;
`endif
      default: alu_res = '0;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic            is_shift, ld_sh;
  logic [XLEN-1:0] shreg, sh_step;
  logic [SW-1:0]   cnt;
  logic [3:0]      sh_op;

  assign is_shift = (aluctrl == OP_SLL) || (aluctrl == OP_SRL) || (aluctrl == OP_SRA);

  always_comb begin
    sh_step = shreg;
    case (sh_op)
      OP_SLL:  sh_step = {shreg[XLEN-2:0], 1'b0};
      OP_SRL:  sh_step = {1'b0, shreg[XLEN-1:1]};
      OP_SRA:  sh_step = {shreg[XLEN-1], shreg[XLEN-1:1]};
      default: sh_step = shreg;
    endcase
  end
`endif

  always_comb begin
    state_nxt = state;
    wr_res    = 1'b0;
    res_nxt   = alu_res;
`ifndef ALU_FAST_SHIFT_EN
    ld_sh     = 1'b0;
    // Last shift step lands straight in result so no partial value is shown.
    if (state == S_SHIFT && cnt == SW'(1)) begin
      wr_res    = 1'b1;
      res_nxt   = sh_step;
      state_nxt = S_DONE;
    end
`endif
    if (state == S_DONE && out_ready)
      state_nxt = S_IDLE;
    // Accept overrides the retire above: DONE -> DONE/SHIFT on the same edge.
    if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
      if (is_shift && shamt != '0) begin
        ld_sh     = 1'b1;
        state_nxt = S_SHIFT;
      end else
`endif
      begin
        wr_res    = 1'b1;
        state_nxt = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (wr_res) begin
      result <= res_nxt;
      zero   <= (res_nxt == '0);
    end
  end

`ifndef ALU_FAST_SHIFT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      sh_op <= '0;
    end else if (ld_sh) begin
      shreg <= src_a;
      cnt   <= shamt;
      sh_op <= aluctrl;
    end else if (state == S_SHIFT) begin
      shreg <= sh_step;
      cnt   <= cnt - SW'(1);
    end
  end
`endif

endmodule
